// File: rtl/booth_dec_accum.sv
`default_nettype none
// ============================================================================
// Module   : booth_dec_accum
// Purpose  : Sequential radix-4 Booth decoder and accumulator. Latches a
//            signed multiplicand, accepts one {single,double,neg} Booth digit
//            per handshake (LS digit first), and accumulates the selected
//            partial product (0, +/-M, +/-2M), shifted 2 bits per digit, into
//            a 2*WIDTH-bit signed product.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start_i             - begin an operation (sampled in IDLE)
//            multiplicand_i      - signed M, latched on accepted start
//            dig_valid_i/_ready_o- Booth digit handshake
//            single_i/double_i/neg_i - encoded Booth digit
//            busy_o              - high in ACCUM and DONE
//            out_valid_o/out_ready_i - product handshake
//            product_o           - signed M * multiplier
//            err_o               - sticky illegal-digit flag for this operation
// Revision : 1.0 - initial release
// ============================================================================
module booth_dec_accum #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic                 dig_valid_i,
  output logic                 dig_ready_o,
  input  logic                 single_i,
  input  logic                 double_i,
  input  logic                 neg_i,
  output logic                 busy_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 err_o
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic               err_q, err_d;

  logic [WIDTH+1:0]   m_ext;
  logic [WIDTH+1:0]   sel;
  logic [WIDTH+1:0]   pp;
  logic [2*WIDTH-1:0] pp_ext;
  logic [2*WIDTH-1:0] pp_shift;
  logic               illegal;
  logic               last_digit;

  // Partial-product datapath. M is widened by two bits so that 2M and its
  // negation (including -2 * -2^(WIDTH-1)) are exact before sign extension.
  always_comb begin
    m_ext      = {{2{m_q[WIDTH-1]}}, m_q};
    illegal    = single_i & double_i;
    sel        = '0;
    if (!illegal) begin
      if (single_i) begin
        sel = m_ext;
      end else if (double_i) begin
        sel = m_ext << 1;
      end
    end
    // neg with zero magnitude yields -0 == 0, so no special case is needed.
    pp         = neg_i ? -sel : sel;
    pp_ext     = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
    pp_shift   = pp_ext << {count_q, 1'b0};
    last_digit = (count_q == CW'(N-1));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          m_d     = multiplicand_i;
          acc_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (dig_valid_i) begin
          acc_d   = acc_q + pp_shift;
          count_d = count_q + CW'(1);
          if (illegal) begin
            err_d = 1'b1;
          end
          if (last_digit) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign dig_ready_o = (state_q == S_ACCUM);
  assign busy_o      = (state_q != S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign product_o   = acc_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_dec_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_dec_accum
// Purpose  : Self-checking bench for booth_dec_accum (WIDTH=8). Directed
//            vector table plus random operations checked against an
//            arithmetic model (product = M * sum(digit_k * 4^k)).
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_dec_accum;

  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic                 dig_valid;
  logic                 dig_ready;
  logic                 single_d;
  logic                 double_d;
  logic                 neg_d;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 err;

  int n_chk;
  int n_err;

  booth_dec_accum #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .multiplicand_i (multiplicand),
    .dig_valid_i    (dig_valid),
    .dig_ready_o    (dig_ready),
    .single_i       (single_d),
    .double_i       (double_d),
    .neg_i          (neg_d),
    .busy_o         (busy),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .product_o      (product),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digits packed 3 bits each, digit k at [3k+2:3k] = {single, double, neg}.
  typedef struct {
    logic [7:0]  m;
    logic [11:0] digs;
    int          gap;
    int          hold;
    logic [15:0] exp_p;
    logic        exp_e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: decode every digit to an integer, build the multiplier, multiply.
  task automatic model(input logic [7:0] m, input logic [11:0] digs,
                       output logic [15:0] p, output logic e);
    longint mult;
    longint ms;
    longint prod;
    int     mag;
    logic [2:0] c;
    mult = 0;
    e    = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = digs[3*k +: 3];
      if (c[2] && c[1]) begin
        mag = 0;
        e   = 1'b1;
      end else if (c[2]) begin
        mag = 1;
      end else if (c[1]) begin
        mag = 2;
      end else begin
        mag = 0;
      end
      if (c[0]) mag = -mag;
      mult = mult + longint'(mag) * (longint'(1) << (2 * k));
    end
    ms   = longint'($signed(m));
    prod = ms * mult;
    p    = prod[15:0];
  endtask

  // One full operation; all driving and sampling happens on the falling edge.
  task automatic run_op(input logic [7:0] m, input logic [11:0] digs, input int gap,
                        input int hold, input logic [15:0] exp_p, input logic exp_e,
                        input string nm);
    logic early;
    logic not_ready;
    start        = 1'b1;
    multiplicand = m;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 8'($urandom);
    chk({nm, ".busy1"}, 32'(busy), 32'd1);
    chk({nm, ".rdy1"}, 32'(dig_ready), 32'd1);
    chk({nm, ".errclr"}, 32'(err), 32'd0);
    early     = 1'b0;
    not_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < gap; g++) begin
        dig_valid = 1'b0;
        start     = 1'b1;
        {single_d, double_d, neg_d} = 3'($urandom);
        @(negedge clk);
        if (out_valid) early = 1'b1;
      end
      start     = 1'b0;
      dig_valid = 1'b1;
      {single_d, double_d, neg_d} = digs[3*k +: 3];
      if (!dig_ready) not_ready = 1'b1;
      @(negedge clk);
      dig_valid = 1'b0;
      if (k < N - 1 && out_valid) early = 1'b1;
    end
    chk({nm, ".early_ov"}, 32'(early), 32'd0);
    chk({nm, ".rdy_accum"}, 32'(not_ready), 32'd0);
    chk({nm, ".ov"}, 32'(out_valid), 32'd1);
    chk({nm, ".rdy_done"}, 32'(dig_ready), 32'd0);
    chk({nm, ".product"}, 32'(product), 32'(exp_p));
    chk({nm, ".err"}, 32'(err), 32'(exp_e));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = 1'b1;
      dig_valid = 1'b1;
      {single_d, double_d, neg_d} = 3'b100;
      @(negedge clk);
      chk({nm, ".hold_ov"}, 32'(out_valid), 32'd1);
      chk({nm, ".hold_p"}, 32'(product), 32'(exp_p));
    end
    dig_valid = 1'b0;
    // start coinciding with the output handshake must be ignored.
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk({nm, ".ov_drop"}, 32'(out_valid), 32'd0);
    chk({nm, ".idle"}, 32'(busy), 32'd0);
  endtask

  vec_t tbl[7];

  initial begin
    logic [15:0] ep;
    logic        ee;
    logic [7:0]  rm;
    logic [11:0] rd;

    n_chk = 0;
    n_err = 0;
    tbl[0] = '{8'h03, {3'b000, 3'b000, 3'b100, 3'b100}, 0, 0, 16'h000F, 1'b0};
    tbl[1] = '{8'hFD, {3'b001, 3'b001, 3'b001, 3'b101}, 0, 1, 16'h0003, 1'b0};
    tbl[2] = '{8'h80, {3'b011, 3'b000, 3'b000, 3'b000}, 2, 3, 16'h4000, 1'b0};
    tbl[3] = '{8'h03, {3'b000, 3'b000, 3'b000, 3'b110}, 0, 0, 16'h0000, 1'b1};
    tbl[4] = '{8'h03, {3'b000, 3'b000, 3'b100, 3'b100}, 1, 0, 16'h000F, 1'b0};
    tbl[5] = '{8'h7F, {3'b011, 3'b000, 3'b000, 3'b000}, 0, 0, 16'hC080, 1'b0};
    tbl[6] = '{8'h80, {3'b010, 3'b000, 3'b000, 3'b000}, 0, 2, 16'hC000, 1'b0};

    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    dig_valid    = 1'b0;
    {single_d, double_d, neg_d} = 3'b000;
    out_ready    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.rdy", 32'(dig_ready), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.product", 32'(product), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // dig_valid in IDLE must be ignored.
    dig_valid = 1'b1;
    {single_d, double_d, neg_d} = 3'b100;
    @(negedge clk);
    dig_valid = 1'b0;
    chk("idle_dig.busy", 32'(busy), 32'd0);
    chk("idle_dig.product", 32'(product), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].m, tbl[i].digs, tbl[i].gap, tbl[i].hold,
             tbl[i].exp_p, tbl[i].exp_e, $sformatf("vec%0d", i));
    end

    // Reset after two accepted digits.
    start        = 1'b1;
    multiplicand = 8'h03;
    @(negedge clk);
    start        = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dig_valid = 1'b1;
      {single_d, double_d, neg_d} = 3'b110;
      @(negedge clk);
    end
    dig_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.rdy", 32'(dig_ready), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.ov", 32'(out_valid), 32'd0);
    chk("midrst.err", 32'(err), 32'd0);
    chk("midrst.product", 32'(product), 32'd0);
    run_op(8'h03, {3'b000, 3'b000, 3'b100, 3'b100}, 0, 0, 16'h000F, 1'b0, "postrst");

    // Random operations against the arithmetic model.
    for (int r = 0; r < 24; r++) begin
      rm = 8'($urandom);
      rd = 12'($urandom);
      if (r % 8 == 0) rm = 8'h80;
      model(rm, rd, ep, ee);
      run_op(rm, rd, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             ep, ee, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/booth_dec_accum.md
# booth_dec_accum

Sequential radix-4 Booth decoder and accumulator: the consuming end of the Booth encoder's `{single, double, neg}` digit interface. It latches a signed multiplicand and accepts one encoded Booth digit per handshake, least-significant digit first. For each digit it selects 0, ±M or ±2M and accumulates the partial product, shifted by two bits per digit, into a 2·WIDTH-bit signed product. It sits between the encoder array and the downstream result consumer in the multiplier datapath.

## Interface
- `WIDTH`, default 16: multiplicand/multiplier width in bits. Must be even and ≥ 4. Digits per operation N = WIDTH/2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `multiplicand`  in  WIDTH  signed M; latched on an accepted `start`.
- `dig_valid`  in  1  a Booth digit is present.
- `dig_ready`  out  1  block accepts a digit this cycle.
- `single`  in  1  digit magnitude 1.
- `double`  in  1  digit magnitude 2.
- `neg`  in  1  digit sign is negative.
- `busy`  out  1  high in ACCUM and DONE.
- `out_valid`  out  1  `product` is valid.
- `out_ready`  in  1  consumer accepts `product`.
- `product`  out  2·WIDTH  signed M × multiplier; registered.
- `err`  out  1  sticky flag: an illegal digit was seen in the current operation.

## Operation
- States: IDLE, ACCUM, DONE.
- **IDLE**
  - When `start` = 1: latch M, clear the accumulator, digit count and `err`, then go to ACCUM.
  - `dig_valid` is ignored.
- **ACCUM**
  - `dig_ready` = 1.
  - On `dig_valid` & `dig_ready`, compute the partial product:
    - sel = M if `single`; 2M if `double`; 0 if neither.
    - pp = −sel if `neg`, else sel.
    - pp is WIDTH+2 bits signed, sign-extended to 2·WIDTH, then shifted left by 2·count.
    - acc ← acc + shifted pp, modulo 2^(2·WIDTH).
  - Illegal digit (`single` & `double`): pp = 0 and `err` ← 1.
  - `neg` alone (encoder code 7) is negative zero: pp = 0, and it is legal.
  - count increments on every accepted digit.
  - When digit N−1 is accepted: go to DONE.
  - `start` is ignored.
- **DONE**
  - `out_valid` = 1 and `product` = acc; both hold stable until `out_ready`.
  - On `out_valid` & `out_ready`: go to IDLE.
  - `start` and `dig_valid` are ignored; `dig_ready` = 0.
- Arithmetic: 2·WIDTH bits are sufficient for all legal digit sequences, including M = −2^(WIDTH−1). No saturation.
- `err` remains readable in DONE and clears only on the next accepted `start` or on `rst`.

## Timing
- Reset values: state IDLE; `dig_ready`, `busy`, `out_valid` and `err` = 0; `product` = 0; count = 0.
- `rst` mid-operation, in any state, returns to IDLE next edge. The partial accumulation is discarded and no `out_valid` is produced.
- Relative to `start` sampled at edge 0:
  - `busy` and `dig_ready` are high from cycle 1.
  - Digit k is accepted no earlier than cycle 1+k.
- `out_valid` rises the cycle after the last digit is accepted. Minimum start-to-`out_valid` latency is N+1 cycles.
- Gaps in `dig_valid` stall accumulation with no state change.
- Holding `out_ready` = 1 in DONE gives a one-cycle `out_valid` pulse.
- The earliest new `start` is sampled in IDLE, i.e. one cycle after the output handshake. Back-to-back throughput is N+2 cycles per product.
- `start` asserted in the same cycle as the output handshake is ignored.

## Test plan
- **Basic, positive operands.** WIDTH=8, M=3; digits (s,d,n) = (1,0,0), (1,0,0), (0,0,0), (0,0,0) (multiplier 5) → `product` = 16'h000F; `out_valid` at cycle 5; `err` = 0.
- **Negative operands.** WIDTH=8, M=8'hFD (−3); digits (1,0,1), (0,0,1), (0,0,1), (0,0,1) (multiplier −1) → `product` = 16'h0003.
- **Extreme values with backpressure.** WIDTH=8, M=8'h80; digits (0,0,0) ×3, then (0,1,1) (multiplier −128) → `product` = 16'h4000.
  - Insert two-cycle `dig_valid` gaps between digits; hold `out_ready` = 0 for 3 cycles.
  - Required: `product` and `out_valid` stay stable, and one handshake returns the block to IDLE.
- **Illegal digit.** M=3, first digit (1,1,0), remaining digits 0 → `product` = 0 and `err` = 1 in DONE. The next `start` clears `err`.
- **Reset mid-operation.** Assert `rst` after 2 accepted digits → next cycle IDLE with all outputs at reset values. A fresh 3×5 operation then yields 16'h000F.
- **Ignored inputs outside their state.** `start` pulsed during ACCUM and DONE, and `dig_valid` pulsed in IDLE → no effect on `product`, count or state.
